// File: rtl/clock_monitor_pkg.sv
// Shared types and default widths for the clock monitor.
package clock_monitor_pkg;

   localparam int DEF_CNT_W       = 16;
   localparam int DEF_EDGE_CNT_W  = 32;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2
   } state_e;

endpackage

// File: rtl/clock_monitor_sync_cell.sv
// Multi-flop synchronizer bringing the monitored clock into the clk domain.
module sync_cell #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic sync_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
      end
   end

   assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/clock_monitor.sv
// Period/edge monitor for an asynchronous clock sampled by clk.
// Optional min/max period history is enabled with CLOCK_MONITOR_HIST_EN.
module clock_monitor
   import clock_monitor_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int EDGE_CNT_W  = DEF_EDGE_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mon_in,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [CNT_W-1:0]      period_min,
   input  logic [CNT_W-1:0]      period_max,
   output logic [EDGE_CNT_W-1:0] edge_count,
   output logic [CNT_W-1:0]      last_period,
   output logic                  period_valid,
   output logic                  too_fast,
   output logic                  too_slow,
   output logic                  stuck,
   output logic                  err_sticky
`ifdef CLOCK_MONITOR_HIST_EN
   ,
   output logic [CNT_W-1:0]      min_seen,
   output logic [CNT_W-1:0]      max_seen
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic                  mon_sync;
   logic                  hist_q;
   logic                  rise_q;
   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic [EDGE_CNT_W-1:0] edge_q, edge_d;
   logic [CNT_W-1:0]      last_q, last_d;
   logic                  pv_q, pv_d;
   logic                  fast_q, fast_d;
   logic                  slow_q, slow_d;
   logic                  stuck_prev_q;
   logic                  err_q, err_d;

   sync_cell #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (mon_in),
      .sync_o  (mon_sync)
   );

   // Registered rise pulse keeps the edge detector off the compare path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         hist_q <= mon_sync;
         rise_q <= mon_sync & ~hist_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    state_d = ST_ARM;
            ST_ARM:     if (rise_q && (cnt_q <= CNT_ONE)) state_d = ST_MEASURE;
            ST_MEASURE: state_d = ST_MEASURE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // Saturation sets ovf so a period longer than the counter range still flags too_slow.
   always_comb begin
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      edge_d = edge_q;
      last_d = last_q;
      pv_d   = 1'b0;
      fast_d = 1'b0;
      slow_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            ovf_d = 1'b0;
         end
         ST_ARM: begin
            if (rise_q) begin
               cnt_d  = CNT_ONE;
               ovf_d  = 1'b0;
               edge_d = edge_q + 1'b1;
            end
         end
         ST_MEASURE: begin
            if (rise_q) begin
               last_d = cnt_q;
               pv_d   = 1'b1;
               fast_d = (cnt_q < period_min);
               slow_d = (cnt_q > period_max) || ovf_q;
               cnt_d  = CNT_ONE;
               ovf_d  = 1'b0;
               edge_d = edge_q + 1'b1;
            end else if (cnt_q == CNT_MAX) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d = '0;
            ovf_d = 1'b0;
         end
      endcase
      if (clear) begin
         edge_d = '0;
      end
      err_d = clear ? 1'b0 : (err_q | fast_d | slow_d | (stuck & ~stuck_prev_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         edge_q       <= '0;
         last_q       <= '0;
         pv_q         <= 1'b0;
         fast_q       <= 1'b0;
         slow_q       <= 1'b0;
         stuck_prev_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         edge_q       <= edge_d;
         last_q       <= last_d;
         pv_q         <= pv_d;
         fast_q       <= fast_d;
         slow_q       <= slow_d;
         stuck_prev_q <= stuck;
         err_q        <= err_d;
      end
   end

   assign stuck        = (state_q == ST_MEASURE) && ((cnt_q > period_max) || ovf_q);
   assign edge_count   = edge_q;
   assign last_period  = last_q;
   assign period_valid = pv_q;
   assign too_fast     = fast_q;
   assign too_slow     = slow_q;
   assign err_sticky   = err_q;

`ifdef CLOCK_MONITOR_HIST_EN
   logic [CNT_W-1:0] min_q, max_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q <= '1;
         max_q <= '0;
      end else if (clear) begin
         min_q <= '1;
         max_q <= '0;
      end else if (pv_d) begin
         if (last_d < min_q) min_q <= last_d;
         if (last_d > max_q) max_q <= last_d;
      end
   end

   assign min_seen = min_q;
   assign max_seen = max_q;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench: stimulus predicts each rise's outcome from drive times, a monitor compares.
module tb_clock_monitor;

   localparam int SYNC = 2;
   localparam int CW   = 16;
   localparam int CWS  = 4;
   localparam int EW   = 32;
   localparam int SMAX = (1 << CWS) - 1;

   logic clk = 1'b0;
   logic rst_n, mon_in, enable, clear;
   logic [CW-1:0]  pmin, pmax;
   logic [CWS-1:0] pmin_s, pmax_s;

   logic [EW-1:0]  edge_count, edge_count_s;
   logic [CW-1:0]  last_period;
   logic [CWS-1:0] last_period_s;
   logic period_valid, too_fast, too_slow, stuck, err_sticky;
   logic period_valid_s, too_fast_s, too_slow_s, stuck_s, err_sticky_s;
`ifdef CLOCK_MONITOR_HIST_EN
   logic [CW-1:0]  min_seen, max_seen;
   logic [CWS-1:0] min_seen_s, max_seen_s;
`endif

   clock_monitor #(.CNT_W(CW), .EDGE_CNT_W(EW), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .mon_in(mon_in), .enable(enable), .clear(clear),
      .period_min(pmin), .period_max(pmax),
      .edge_count(edge_count), .last_period(last_period), .period_valid(period_valid),
      .too_fast(too_fast), .too_slow(too_slow), .stuck(stuck), .err_sticky(err_sticky)
`ifdef CLOCK_MONITOR_HIST_EN
      , .min_seen(min_seen), .max_seen(max_seen)
`endif
   );

   clock_monitor #(.CNT_W(CWS), .EDGE_CNT_W(EW), .SYNC_STAGES(SYNC)) dut_s (
      .clk(clk), .rst_n(rst_n), .mon_in(mon_in), .enable(enable), .clear(clear),
      .period_min(pmin_s), .period_max(pmax_s),
      .edge_count(edge_count_s), .last_period(last_period_s), .period_valid(period_valid_s),
      .too_fast(too_fast_s), .too_slow(too_slow_s), .stuck(stuck_s), .err_sticky(err_sticky_s)
`ifdef CLOCK_MONITOR_HIST_EN
      , .min_seen(min_seen_s), .max_seen(max_seen_s)
`endif
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic clr_seen = 1'b0;
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      clr_seen <= clear;
   end

   typedef struct {
      int cyc;
      bit rise;
      bit en;
      bit pv;
      int per;
      bit tf;
      bit ts;
      int per_s;
      bit ts_s;
      int ec;
   } item_t;

   item_t q[$];
   int nvec = 0;
   int nerr = 0;

   // Stimulus-side model: whether the next rise only arms, last rise drive cycle, edge count.
   bit armed = 1'b0;
   bit en_m  = 1'b0;
   int last_d = 0;
   int ec_m  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   function automatic item_t predict_rise(input int d);
      item_t it;
      int p;
      it = '{default: 0};
      it.cyc  = d + SYNC + 1;
      it.rise = 1'b1;
      it.en   = en_m;
      if (en_m) begin
         ec_m++;
         if (armed) begin
            p        = d - last_d;
            it.pv    = 1'b1;
            it.per   = p;
            it.tf    = (p < int'(pmin));
            it.ts    = (p > int'(pmax));
            it.per_s = (p > SMAX) ? SMAX : p;
            it.ts_s  = (p > int'(pmax_s));
         end
         armed  = 1'b1;
         last_d = d;
      end
      it.ec = ec_m;
      return it;
   endfunction

   task automatic rise_pulse(input int hi, input int lo);
      mon_in = 1'b1;
      q.push_back(predict_rise(cyc + 1));
      step(hi);
      mon_in = 1'b0;
      step(lo);
   endtask

   // Clear lands on the very edge where the FSM consumes this rise.
   task automatic clear_on_rise();
      item_t it;
      mon_in = 1'b1;
      it     = predict_rise(cyc + 1);
      ec_m   = 0;
      it.ec  = 0;
      q.push_back(it);
      step(SYNC + 1);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      step(2);
      mon_in = 1'b0;
      step(4);
   endtask

   task automatic clear_pulse();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      ec_m  = 0;
   endtask

   task automatic set_enable(input bit v);
      item_t it;
      enable = v;
      if (!v) begin
         it      = '{default: 0};
         it.cyc  = cyc + 1;
         it.ec   = ec_m;
         q.push_back(it);
         en_m  = 1'b0;
         armed = 1'b0;
      end else begin
         en_m = 1'b1;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         step(1);
         n++;
      end
      if (q.size() != 0) begin
         nvec++;
         nerr++;
         $display("FAIL drain at cycle %0d: %0d responses outstanding, expected 0", cyc, q.size());
         q.delete();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      armed = 1'b0;
      ec_m  = 0;
   endtask

   // Monitor-side model of stuck level and sticky error.
   bit meas = 1'b0;
   int since = 0;
   bit sk1 = 1'b0, sk2 = 1'b0, sk1s = 1'b0, sk2s = 1'b0;
   bit exp_err = 1'b0, exp_err_s = 1'b0;
   int mn = 0, mx = 0;

   always @(negedge clk) begin
      bit e_stuck, e_stuck_s, set_e, set_es;
      if (!rst_n) begin
         meas = 1'b0; sk1 = 1'b0; sk2 = 1'b0; sk1s = 1'b0; sk2s = 1'b0;
         exp_err = 1'b0; exp_err_s = 1'b0; mn = (1 << CW) - 1; mx = 0;
         chk("rst_edge_count", edge_count, 0);
         chk("rst_last_period", last_period, 0);
         chk("rst_flags", {period_valid, too_fast, too_slow, stuck, err_sticky}, 0);
         chk("rst_small", {last_period_s, period_valid_s, too_slow_s, stuck_s, err_sticky_s}, 0);
`ifdef CLOCK_MONITOR_HIST_EN
         chk("rst_hist", {min_seen, max_seen}, {{CW{1'b1}}, {CW{1'b0}}});
`endif
      end else begin
         set_e  = sk1 & ~sk2;
         set_es = sk1s & ~sk2s;
         if (q.size() != 0 && q[0].cyc < cyc) begin
            nvec++;
            nerr++;
            $display("FAIL missed_response at cycle %0d: expected at cycle %0d", cyc, q[0].cyc);
            void'(q.pop_front());
         end
         if (q.size() != 0 && q[0].cyc == cyc) begin
            item_t it;
            it = q.pop_front();
            chk("period_valid", {period_valid, period_valid_s}, {it.pv, it.pv});
            chk("edge_count", {edge_count, edge_count_s}, {it.ec[EW-1:0], it.ec[EW-1:0]});
            if (it.rise && it.en) begin
               meas  = 1'b1;
               since = cyc - 1;
            end
            if (!it.rise) meas = 1'b0;
            if (it.pv) begin
               chk("last_period", last_period, it.per);
               chk("too_fast_slow", {too_fast, too_slow}, {it.tf, it.ts});
               chk("small_period", last_period_s, it.per_s);
               chk("small_flags", {too_fast_s, too_slow_s}, {1'b0, it.ts_s});
               set_e  = set_e | it.tf | it.ts;
               set_es = set_es | it.ts_s;
               if (it.per < mn) mn = it.per;
               if (it.per > mx) mx = it.per;
            end else begin
               chk("no_violation", {too_fast, too_slow, too_fast_s, too_slow_s}, 0);
            end
`ifdef CLOCK_MONITOR_HIST_EN
            if (it.pv && !clr_seen) chk("hist", {min_seen, max_seen}, {mn[CW-1:0], mx[CW-1:0]});
`endif
         end else begin
            chk("idle_pulses", {period_valid, too_fast, too_slow, period_valid_s, too_fast_s, too_slow_s}, 0);
         end
         if (clr_seen) begin
            exp_err = 1'b0; exp_err_s = 1'b0; mn = (1 << CW) - 1; mx = 0;
         end else begin
            exp_err   = exp_err | set_e;
            exp_err_s = exp_err_s | set_es;
         end
         e_stuck   = meas && ((cyc - since) > int'(pmax));
         e_stuck_s = meas && ((cyc - since) > int'(pmax_s));
         chk("stuck", {stuck, stuck_s}, {e_stuck, e_stuck_s});
         chk("err_sticky", {err_sticky, err_sticky_s}, {exp_err, exp_err_s});
         sk2 = sk1;  sk1 = e_stuck;
         sk2s = sk1s; sk1s = e_stuck_s;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; mon_in = 1'b0; enable = 1'b0; clear = 1'b0;
      pmin = 16'd8; pmax = 16'd12; pmin_s = '0; pmax_s = '1;
      #1 rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(2);
      set_enable(1'b1);
      step(3);

      // Nominal 10-cycle period inside the 8..12 window.
      repeat (6) rise_pulse(5, 5);
      drain();

      // 6-cycle period is too fast; the sticky error holds until clear.
      repeat (5) rise_pulse(3, 3);
      drain();
      step(3);
      clear_pulse();
      step(2);

      // Long low phase drives stuck; 20/32-cycle periods saturate the 4-bit counter.
      repeat (2) rise_pulse(2, 30);
      repeat (2) rise_pulse(10, 10);
      drain();

      // Random periods against random thresholds (min may exceed max).
      for (int k = 0; k < 4; k++) begin
         drain();
         clear_pulse();
         pmin = 16'($urandom_range(2, 14));
         pmax = 16'($urandom_range(2, 20));
         repeat (10) rise_pulse($urandom_range(1, 8), $urandom_range(1, 12));
      end

      // Clear coincident with a rise.
      drain();
      pmin = 16'd8; pmax = 16'd12;
      repeat (2) rise_pulse(3, 3);
      clear_on_rise();
      repeat (2) rise_pulse(5, 5);

      // Disable mid-measure; edges while disabled are not counted.
      drain();
      set_enable(1'b0);
      step(3);
      rise_pulse(4, 4);
      drain();
      set_enable(1'b1);
      step(3);
      repeat (4) rise_pulse(4, 6);

      // Reset mid-measure, then the first rise only arms.
      drain();
      step(4);
      do_reset();
      step(3);
      repeat (3) rise_pulse(5, 5);
      drain();
      step(5);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
